// File: rtl/program_loader_if.sv
// Host byte channel between the program loader and its UART/JTAG bridge.
// The loader is the slave: it sinks rx bytes and sources tx bytes.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-command parser that loads instruction/data RAMs, starts/stops the
// cores and reads data-RAM words back to the host.
module program_loader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    program_loader_if.slave   host,
    output logic [ADDR_W-1:0] addr_ext,
    output logic [DATA_W-1:0] Data_in_ins,
    output logic [DATA_W-1:0] Data_in_dram,
    output logic              iram_write_ext_1,
    output logic              iram_write_ext_2,
    output logic              dram_write_ext,
    output logic              start_2,
    output logic              start_3,
    output logic              start_4,
    output logic              read_en_ext,
    output logic              start,
    input  logic [DATA_W-1:0] dram_in_1,
    output logic              busy,
    output logic              err
);
    typedef enum logic [4:0] {
        StIdle, StCntH, StCntL, StAdrH, StAdrL, StDatH, StDatL, StWr, StClr,
        StRun, StRaH, StRaL, StRdReq, StRdWait, StTxH, StTxL, StRdClr
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d, rd_q, rd_d;
    logic [3:0]        wait_q, wait_d;
    logic              err_d, accept;
    logic [15:0]       field;

    logic              rx_ready_q, tx_valid_q, busy_q, err_q, start_q;
    logic              start_2_q, start_3_q, start_4_q, read_en_q;
    logic              iram1_q, iram2_q, dram_we_q;
    logic [7:0]        tx_data_q;
    logic [ADDR_W-1:0] addr_ext_q;
    logic [DATA_W-1:0] data_q;

    assign accept = host.rx_valid && rx_ready_q;
    assign field  = {hi_q, host.rx_data};

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        rd_d    = rd_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: if (accept) begin
                case (host.rx_data)
                    8'h01, 8'h02, 8'h03, 8'h04: begin
                        cmd_d   = host.rx_data[2:0];
                        state_d = StCntH;
                    end
                    8'h05:   state_d = StRun;
                    8'h07:   state_d = StRaH;
                    default: err_d = 1'b1;
                endcase
            end
            StCntH: if (accept) begin hi_d = host.rx_data; state_d = StCntL; end
            StCntL: if (accept) begin cnt_d = field[ADDR_W-1:0]; state_d = StAdrH; end
            StAdrH: if (accept) begin hi_d = host.rx_data; state_d = StAdrL; end
            StAdrL: if (accept) begin
                addr_d  = field[ADDR_W-1:0];
                state_d = (cnt_q == '0) ? StIdle : StDatH;
            end
            StDatH: if (accept) begin hi_d = host.rx_data; state_d = StDatL; end
            StDatL: if (accept) begin word_d = field[DATA_W-1:0]; state_d = StWr; end
            StWr:   state_d = StClr;
            StClr: begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - ADDR_W'(1);
                state_d = (cnt_q == ADDR_W'(1)) ? StIdle : StDatH;
            end
            StRun: if (accept) begin
                if (host.rx_data == 8'h06) state_d = StIdle;
                else                       err_d   = 1'b1;
            end
            StRaH: if (accept) begin hi_d = host.rx_data; state_d = StRaL; end
            StRaL: if (accept) begin addr_d = field[ADDR_W-1:0]; state_d = StRdReq; end
            StRdReq: begin wait_d = '0; state_d = StRdWait; end
            StRdWait: begin
                if (wait_q == 4'(RD_LAT - 1)) begin
                    rd_d    = dram_in_1;
                    state_d = StTxH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StTxH:   if (host.tx_ready) state_d = StTxL;
            StTxL:   if (host.tx_ready) state_d = StRdClr;
            StRdClr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state; cmd bits double as write selects
    // (bit0 core 1, bit1 core 2, bit2 data RAM).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            rd_q       <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            start_2_q  <= 1'b0;
            start_3_q  <= 1'b0;
            start_4_q  <= 1'b0;
            read_en_q  <= 1'b0;
            iram1_q    <= 1'b0;
            iram2_q    <= 1'b0;
            dram_we_q  <= 1'b0;
            addr_ext_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            rd_q       <= rd_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            rx_ready_q <= state_d inside {StIdle, StRun, StCntH, StCntL, StAdrH, StAdrL,
                                          StDatH, StDatL, StRaH, StRaL};
            tx_valid_q <= state_d inside {StTxH, StTxL};
            busy_q     <= !(state_d inside {StIdle, StRun});
            start_q    <= (state_d == StRun);
            start_2_q  <= (state_d inside {StWr, StClr}) && !cmd_d[2];
            start_3_q  <= (state_d inside {StWr, StClr}) && cmd_d[2];
            start_4_q  <= state_d inside {StRdReq, StRdWait, StTxH, StTxL, StRdClr};
            read_en_q  <= state_d inside {StRdReq, StRdWait, StTxH, StTxL};
            iram1_q    <= (state_d == StWr) && cmd_d[0];
            iram2_q    <= (state_d == StWr) && cmd_d[1];
            dram_we_q  <= (state_d == StWr) && cmd_d[2];
            if (state_d == StWr || state_d == StRdReq) addr_ext_q <= addr_d;
            if (state_d == StWr) data_q <= word_d;
            if (state_d == StTxH && state_q != StTxH) tx_data_q <= rd_d[DATA_W-1 -: 8];
            else if (state_d == StTxL && state_q == StTxH) tx_data_q <= rd_q[7:0];
        end
    end

    assign host.rx_ready    = rx_ready_q;
    assign host.tx_valid    = tx_valid_q;
    assign host.tx_data     = tx_data_q;
    assign addr_ext         = addr_ext_q;
    assign Data_in_ins      = data_q;
    assign Data_in_dram     = data_q;
    assign iram_write_ext_1 = iram1_q;
    assign iram_write_ext_2 = iram2_q;
    assign dram_write_ext   = dram_we_q;
    assign start_2          = start_2_q;
    assign start_3          = start_3_q;
    assign start_4          = start_4_q;
    assign read_en_ext      = read_en_q;
    assign start            = start_q;
    assign busy             = busy_q;
    assign err              = err_q;
endmodule
